// File: rtl/s_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback all in one clock.
// A setup port preloads instruction memory, registers and start PC before running.
module s_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_pc_instr_start_addr,
    input  logic [31:0] inst_mem_addr,
    input  logic [31:0] inst_mem_data,
    input  logic [4:0]  load_reg_addr,
    input  logic [31:0] load_reg_data,
    input  logic        setup,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst_data,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic [31:0] o_imm_out,
    output logic [31:0] o_ALU_out,
    output logic        o_ALU_br_cond,
    output logic [31:0] o_RAM_data_out,
    output logic [1:0]  o_writeback_sel,
    output logic [31:0] o_rd_writeback
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic [31:0] r_pc;
    logic [31:0] r_regs [32];
    logic [31:0] r_imem [256];
    logic [31:0] r_dmem [256];

    logic [31:0] w_instr, w_imm, w_rs1_d, w_rs2_d, w_a, w_b, w_alu, w_sra;
    logic [31:0] w_ld_word, w_ld, w_st_word, w_wb, w_pc4, w_next_pc;
    logic [15:0] w_ld_half;
    logic [7:0]  w_ld_byte;
    logic [6:0]  w_opc;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [1:0]  w_sel;
    logic        w_br, w_we, w_unused;

    assign w_instr = r_imem[r_pc[9:2]];
    assign w_opc   = w_instr[6:0];
    assign w_rd    = w_instr[11:7];
    assign w_f3    = w_instr[14:12];
    assign w_rs1   = w_instr[19:15];
    assign w_rs2   = w_instr[24:20];
    assign w_rs1_d = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_d = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign w_pc4   = r_pc + 32'd4;
    assign w_unused = ^{inst_mem_addr[31:10], inst_mem_addr[1:0]};

    always_comb begin
        case (w_opc)
            OP_LUI, OP_AUIPC: w_imm = {w_instr[31:12], 12'b0};
            OP_JAL: w_imm = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
            OP_BR:  w_imm = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
            OP_ST:  w_imm = {{21{w_instr[31]}}, w_instr[30:25], w_instr[11:7]};
            default: w_imm = {{21{w_instr[31]}}, w_instr[30:20]};
        endcase
    end

    // Branches reuse the adder for the target, so their comparison is separate.
    assign w_a   = (w_opc == OP_AUIPC || w_opc == OP_JAL || w_opc == OP_BR) ? r_pc : w_rs1_d;
    assign w_b   = (w_opc == OP_REG) ? w_rs2_d : w_imm;
    assign w_sra = $signed(w_a) >>> w_b[4:0];

    always_comb begin
        w_alu = w_a + w_b;
        if (w_opc == OP_IMM || w_opc == OP_REG) begin
            case (w_f3)
                3'b000:  w_alu = (w_opc == OP_REG && w_instr[30]) ? w_a - w_b : w_a + w_b;
                3'b001:  w_alu = w_a << w_b[4:0];
                3'b010:  w_alu = {31'b0, $signed(w_a) < $signed(w_b)};
                3'b011:  w_alu = {31'b0, w_a < w_b};
                3'b100:  w_alu = w_a ^ w_b;
                3'b101:  w_alu = w_instr[30] ? w_sra : (w_a >> w_b[4:0]);
                3'b110:  w_alu = w_a | w_b;
                default: w_alu = w_a & w_b;
            endcase
        end
    end

    always_comb begin
        case (w_f3)
            3'b000:  w_br = (w_rs1_d == w_rs2_d);
            3'b001:  w_br = (w_rs1_d != w_rs2_d);
            3'b100:  w_br = ($signed(w_rs1_d) < $signed(w_rs2_d));
            3'b101:  w_br = ($signed(w_rs1_d) >= $signed(w_rs2_d));
            3'b110:  w_br = (w_rs1_d < w_rs2_d);
            3'b111:  w_br = (w_rs1_d >= w_rs2_d);
            default: w_br = 1'b0;
        endcase
    end

    assign w_ld_word = r_dmem[w_alu[9:2]];
    assign w_ld_byte = w_ld_word[{w_alu[1:0], 3'b000} +: 8];
    assign w_ld_half = w_ld_word[{w_alu[1], 4'b0000} +: 16];

    always_comb begin
        case (w_f3)
            3'b000:  w_ld = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld = {24'b0, w_ld_byte};
            3'b101:  w_ld = {16'b0, w_ld_half};
            default: w_ld = w_ld_word;
        endcase
    end

    // Sub-word stores read-modify-write the addressed word in the same cycle.
    always_comb begin
        w_st_word = w_ld_word;
        case (w_f3[1:0])
            2'b00:   w_st_word[{w_alu[1:0], 3'b000} +: 8] = w_rs2_d[7:0];
            2'b01:   w_st_word[{w_alu[1], 4'b0000} +: 16] = w_rs2_d[15:0];
            default: w_st_word = w_rs2_d;
        endcase
    end

    always_comb begin
        case (w_opc)
            OP_LD:           w_sel = 2'b01;
            OP_JAL, OP_JALR: w_sel = 2'b10;
            OP_LUI:          w_sel = 2'b11;
            default:         w_sel = 2'b00;
        endcase
        case (w_sel)
            2'b01:   w_wb = w_ld;
            2'b10:   w_wb = w_pc4;
            2'b11:   w_wb = w_imm;
            default: w_wb = w_alu;
        endcase
    end

    always_comb begin
        case (w_opc)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG:
                     w_we = !setup && (w_rd != 5'd0);
            default: w_we = 1'b0;
        endcase
        case (w_opc)
            OP_JAL:  w_next_pc = w_alu;
            OP_JALR: w_next_pc = {w_alu[31:1], 1'b0};
            OP_BR:   w_next_pc = w_br ? w_alu : w_pc4;
            default: w_next_pc = w_pc4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_pc <= 32'd0;
        else if (setup) r_pc <= i_pc_instr_start_addr;
        else            r_pc <= w_next_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (setup) begin
            if (load_reg_addr != 5'd0) r_regs[load_reg_addr] <= load_reg_data;
        end else if (w_we) begin
            r_regs[w_rd] <= w_wb;
        end
    end

    // Memories are not reset; their contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (setup) r_imem[inst_mem_addr[9:2]] <= inst_mem_data;
        if (rst_n && !setup && w_opc == OP_ST) r_dmem[w_alu[9:2]] <= w_st_word;
    end

    assign o_pc            = r_pc;
    assign o_inst_data     = w_instr;
    assign o_rs1_data      = w_rs1_d;
    assign o_rs2_data      = w_rs2_d;
    assign o_imm_out       = w_imm;
    assign o_ALU_out       = w_alu;
    assign o_ALU_br_cond   = w_br;
    assign o_RAM_data_out  = w_ld;
    assign o_writeback_sel = w_sel;
    assign o_rd_writeback  = w_wb;
endmodule

// File: tb/tb_s_core.sv
// Bench for s_core: preloads a program covering every instruction class, then
// steps it one cycle at a time against a table of expected per-step outputs.
module tb_s_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_pc_instr_start_addr = 32'd0;
    logic [31:0] inst_mem_addr = 32'd0;
    logic [31:0] inst_mem_data = 32'd0;
    logic [4:0]  load_reg_addr = 5'd0;
    logic [31:0] load_reg_data = 32'd0;
    logic        setup = 1'b1;
    logic [31:0] o_pc, o_inst_data, o_rs1_data, o_rs2_data, o_imm_out, o_ALU_out;
    logic [31:0] o_RAM_data_out, o_rd_writeback;
    logic [1:0]  o_writeback_sel;
    logic        o_ALU_br_cond;

    always #5 clk = ~clk;

    s_core dut (
        .clk(clk), .rst_n(rst_n),
        .i_pc_instr_start_addr(i_pc_instr_start_addr),
        .inst_mem_addr(inst_mem_addr), .inst_mem_data(inst_mem_data),
        .load_reg_addr(load_reg_addr), .load_reg_data(load_reg_data),
        .setup(setup),
        .o_pc(o_pc), .o_inst_data(o_inst_data),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .o_imm_out(o_imm_out), .o_ALU_out(o_ALU_out), .o_ALU_br_cond(o_ALU_br_cond),
        .o_RAM_data_out(o_RAM_data_out), .o_writeback_sel(o_writeback_sel),
        .o_rd_writeback(o_rd_writeback)
    );

    localparam int M_ALU = 1, M_WB = 2, M_RS = 4, M_BR = 8, M_RAM = 16;

    typedef struct {
        logic [31:0] pc, alu, wb, rs1, rs2, ram;
        logic [1:0]  sel;
        logic        br;
        int          mask;
    } exp_t;

    typedef struct {
        logic [31:0] addr, data;
    } ld_t;

    int   total = 0;
    int   bad = 0;
    exp_t vec[26];
    exp_t sbq[$];
    ld_t  prog[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input int mask, input logic [31:0] alu,
                                input logic [31:0] wb, input logic [1:0] sel,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic br, input logic [31:0] ram);
        exp_t e;
        e.pc = pc; e.mask = mask; e.alu = alu; e.wb = wb; e.sel = sel;
        e.rs1 = rs1; e.rs2 = rs2; e.br = br; e.ram = ram;
        return e;
    endfunction

    initial begin
        exp_t e;
        prog = '{
            '{32'h00, 32'h006200B3}, '{32'h04, 32'h00127413}, '{32'h08, 32'h00620033},
            '{32'h0C, 32'h800AA937}, '{32'h10, 32'h00229997}, '{32'h14, 32'h01E00BEF},
            '{32'h30, 32'h01230AB3}, '{32'h34, 32'h01132023}, '{32'h38, 32'h00032603},
            '{32'h3C, 32'h00620463}, '{32'h44, 32'h00621463}, '{32'h48, 32'h000460B3},
            '{32'h4C, 32'h017660B3}, '{32'h50, 32'h0159E0B3}, '{32'h54, 32'h41120133},
            '{32'h58, 32'h40495193}, '{32'h5C, 32'h002232B3}, '{32'h60, 32'h00202223},
            '{32'h64, 32'h01100323}, '{32'h68, 32'h00500383}, '{32'h6C, 32'h00605483},
            '{32'h70, 32'h00402503}, '{32'h74, 32'h00226463}, '{32'h7C, 32'h00224463},
            '{32'h80, 32'h08F205E7}, '{32'h90, 32'h00000000}, '{32'h94, 32'h005580B3}};
        //           pc     mask               alu           wb            sel   rs1           rs2           br    ram
        vec[0]  = mk(32'h04, M_ALU|M_WB,      32'h1,        32'h1,        2'd0, 0,            0,            0,    0);
        vec[1]  = mk(32'h08, M_ALU|M_WB|M_RS, 32'h2,        32'h2,        2'd0, 32'h1,        32'h1,        0,    0);
        vec[2]  = mk(32'h0C, M_WB,            0,            32'h800AA000, 2'd3, 0,            0,            0,    0);
        vec[3]  = mk(32'h10, M_ALU|M_WB,      32'h00229010, 32'h00229010, 2'd0, 0,            0,            0,    0);
        vec[4]  = mk(32'h14, M_ALU|M_WB,      32'h32,       32'h18,       2'd2, 0,            0,            0,    0);
        vec[5]  = mk(32'h32, M_ALU|M_WB|M_RS, 32'h800AA001, 32'h800AA001, 2'd0, 32'h1,        32'h800AA000, 0,    0);
        vec[6]  = mk(32'h36, M_ALU|M_RS,      32'h1,        0,            2'd0, 32'h1,        32'h1101,     0,    0);
        vec[7]  = mk(32'h3A, M_ALU|M_WB|M_RAM,32'h1,        32'h1101,     2'd1, 0,            0,            0,    32'h1101);
        vec[8]  = mk(32'h3E, M_ALU|M_BR,      32'h46,       0,            2'd0, 0,            0,            1'b1, 0);
        vec[9]  = mk(32'h46, M_ALU|M_BR,      32'h4E,       0,            2'd0, 0,            0,            1'b0, 0);
        vec[10] = mk(32'h4A, M_WB|M_RS,       0,            32'h1,        2'd0, 32'h1,        32'h0,        0,    0);
        vec[11] = mk(32'h4E, M_WB|M_RS,       0,            32'h1119,     2'd0, 32'h1101,     32'h18,       0,    0);
        vec[12] = mk(32'h52, M_WB|M_RS,       0,            32'h802AB011, 2'd0, 32'h00229010, 32'h800AA001, 0,    0);
        vec[13] = mk(32'h56, M_WB,            0,            32'hFFFFEF00, 2'd0, 0,            0,            0,    0);
        vec[14] = mk(32'h5A, M_WB,            0,            32'hF800AA00, 2'd0, 0,            0,            0,    0);
        vec[15] = mk(32'h5E, M_WB,            0,            32'h1,        2'd0, 0,            0,            0,    0);
        vec[16] = mk(32'h62, M_ALU|M_RS,      32'h4,        0,            2'd0, 32'h0,        32'hFFFFEF00, 0,    0);
        vec[17] = mk(32'h66, M_ALU,           32'h6,        0,            2'd0, 0,            0,            0,    0);
        vec[18] = mk(32'h6A, M_WB|M_RAM,      0,            32'hFFFFFFEF, 2'd1, 0,            0,            0,    32'hFFFFFFEF);
        vec[19] = mk(32'h6E, M_WB|M_RAM,      0,            32'h0000FF01, 2'd1, 0,            0,            0,    32'h0000FF01);
        vec[20] = mk(32'h72, M_WB|M_RAM,      0,            32'hFF01EF00, 2'd1, 0,            0,            0,    32'hFF01EF00);
        vec[21] = mk(32'h76, M_BR,            0,            0,            2'd0, 0,            0,            1'b1, 0);
        vec[22] = mk(32'h7E, M_BR,            0,            0,            2'd0, 0,            0,            1'b0, 0);
        vec[23] = mk(32'h82, M_ALU|M_WB,      32'h90,       32'h86,       2'd2, 0,            0,            0,    0);
        vec[24] = mk(32'h90, 0,               0,            0,            2'd0, 0,            0,            0,    0);
        vec[25] = mk(32'h94, M_WB|M_RS,       0,            32'h87,       2'd0, 32'h86,       32'h1,        0,    0);

        #2;
        chk("reset pc", o_pc, 32'h0);
        chk("reset rs1", o_rs1_data, 32'h0);
        chk("reset rs2", o_rs2_data, 32'h0);
        i_pc_instr_start_addr = 32'h04;
        @(negedge clk);
        rst_n = 1'b1;

        // Setup: program words every edge, registers on the first three, x0 junk after.
        for (int i = 0; i < 27; i++) begin
            inst_mem_addr = prog[i].addr;
            inst_mem_data = prog[i].data;
            case (i)
                0:       begin load_reg_addr = 5'd4;  load_reg_data = 32'h1;    end
                1:       begin load_reg_addr = 5'd6;  load_reg_data = 32'h1;    end
                2:       begin load_reg_addr = 5'd17; load_reg_data = 32'h1101; end
                default: begin load_reg_addr = 5'd0;  load_reg_data = 32'hDEADBEEF; end
            endcase
            @(negedge clk);
        end
        chk("setup pc", o_pc, 32'h04);
        chk("setup instr", o_inst_data, 32'h00127413);
        setup = 1'b0;

        for (int i = 0; i < 26; i++) begin
            sbq.push_back(vec[i]);
            #1;
            e = sbq.pop_front();
            chk($sformatf("pc@%0d", i), o_pc, e.pc);
            if ((e.mask & M_ALU) != 0) chk($sformatf("alu@%0d", i), o_ALU_out, e.alu);
            if ((e.mask & M_WB) != 0) begin
                chk($sformatf("wb@%0d", i), o_rd_writeback, e.wb);
                chk($sformatf("sel@%0d", i), {30'b0, o_writeback_sel}, {30'b0, e.sel});
            end
            if ((e.mask & M_RS) != 0) begin
                chk($sformatf("rs1@%0d", i), o_rs1_data, e.rs1);
                chk($sformatf("rs2@%0d", i), o_rs2_data, e.rs2);
            end
            if ((e.mask & M_BR) != 0) chk($sformatf("br@%0d", i), {31'b0, o_ALU_br_cond}, {31'b0, e.br});
            if ((e.mask & M_RAM) != 0) chk($sformatf("ram@%0d", i), o_RAM_data_out, e.ram);
            @(negedge clk);
        end

        // Mid-run reset clears PC and registers without waiting for a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst pc", o_pc, 32'h0);
        chk("midrst rs1", o_rs1_data, 32'h0);
        chk("midrst rs2", o_rs2_data, 32'h0);
        chk("midrst alu", o_ALU_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release pc", o_pc, 32'h0);
        @(posedge clk);
        #1;
        chk("resume pc", o_pc, 32'h04);
        chk("resume wb", o_rd_writeback, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
